pipelined_carry_adder: RTL and testbench

Parametrised, pipelined successor of the team's combinational ripple-carry adder. A WIDTH-bit add/subtract is split into STAGES equal slices, one slice per pipeline stage, with the inter-slice carry registered between stages. The block accepts one operation per cycle under a valid/ready handshake with full backpressure. It sits in datapaths where a single-cycle WIDTH-bit carry chain would not meet timing.

---
 rtl/pipelined_carry_adder.sv | 107 ++++++++++
 tb/tb_pipelined_carry_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit add/subtract: one SW-bit slice per stage with a registered inter-slice carry,
// valid bits travelling with the data, and a single global advance enable for backpressure.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub || cin;

  // Stage k sees only the not-yet-added upper bits (REM wide) and the already-finished lower sum bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic             c_in;
    logic             v_in;
    logic [SW:0]      slice;
    logic [LO+SW-1:0] s_nxt;
    logic             v_q;
    logic             c_q;
    logic [LO+SW-1:0] s_q;

    assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign s_nxt = slice[SW-1:0];
    end else begin : g_body
      assign a_in  = g_stg[k-1].g_skew.a_q;
      assign b_in  = g_stg[k-1].g_skew.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_nxt = {slice[SW-1:0], g_stg[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= slice[SW];
        s_q <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SW];
          b_q <= b_in[REM-1:SW];
        end
      end
    end else begin : g_tail
      // Both operand MSBs live in the top slice, so overflow is resolved alongside it.
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (a_in[SW-1] == b_in[SW-1]) && (slice[SW-1] != a_in[SW-1]);
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign overflow  = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed and random checks of pipelined_carry_adder: 16x4 main instance plus (8,1), (8,8), (32,4) sweep.
module tb_pipelined_carry_adder;
  localparam int STG = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;

  logic        sw_vld, sw_cin, sw_sub, sw_rdy;
  logic [31:0] sw_a, sw_b;
  logic        r81, v81, c81, o81, r88, v88, c88, o88, r324, v324, c324, o324;
  logic [7:0]  s81, s88;
  logic [31:0] s324;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ha [256];
  logic [31:0] hb [256];
  logic        hc [256];
  logic        hs [256];

  pipelined_carry_adder #(.WIDTH(16), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .overflow(overflow));

  pipelined_carry_adder #(.WIDTH(8), .STAGES(1)) u81 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_vld), .in_ready(r81), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(v81), .out_ready(sw_rdy), .sum(s81),
    .cout(c81), .overflow(o81));

  pipelined_carry_adder #(.WIDTH(8), .STAGES(8)) u88 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_vld), .in_ready(r88), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(v88), .out_ready(sw_rdy), .sum(s88),
    .cout(c88), .overflow(o88));

  pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) u324 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_vld), .in_ready(r324), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(v324), .out_ready(sw_rdy), .sum(s324),
    .cout(c324), .overflow(o324));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // Golden model: full-width add of a + B' + C0, returned as {overflow, cout, sum}.
  function automatic logic [33:0] gold(input logic [31:0] ai, input logic [31:0] bi,
                                       input logic ci, input logic sb, input int w);
    logic [32:0] m, aa, bb, t;
    logic        co, ov;
    m  = (33'd1 << w) - 33'd1;
    aa = {1'b0, ai} & m;
    bb = (sb ? ~{1'b0, bi} : {1'b0, bi}) & m;
    t  = aa + bb + {32'd0, (sb | ci)};
    co = t[w];
    ov = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return {ov, co, t[31:0] & m[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic one_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    a = ai; b = bi; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < STG; k++) begin
      chk("lat_early", out_valid, 0);
      step();
    end
    chk("lat_valid", out_valid, 1);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", overflow, eo);
    step();
  endtask

  task automatic stream(input int n, input bit bp);
    logic [33:0] q[$];
    logic [63:0] prev;
    bit          prev_stall;
    int          sent, got, idx, first_acc, first_v, first_d, last_d;
    sent = 0; got = 0; idx = 0; first_acc = -1; first_v = -1; first_d = -1; last_d = -1;
    prev = '0; prev_stall = 1'b0;
    while ((sent < n || q.size() != 0) && idx < 2000) begin
      if (sent < n) begin
        in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (bp) out_ready = (idx >= 20 && idx < 30) ? 1'b0 : 1'($urandom_range(0, 1));
      else    out_ready = 1'b1;
      #1;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) chk("stall_hold", {out_valid, overflow, cout, sum}, prev);
      if (out_valid && first_v < 0) first_v = idx;
      if (out_valid && out_ready) begin
        chk("pending", q.size() != 0, 1);
        if (q.size() != 0) chk("result", {overflow, cout, 16'h0, sum}, q.pop_front());
        got++;
        if (first_d < 0) first_d = idx;
        last_d = idx;
      end
      if (in_valid && in_ready) begin
        q.push_back(gold({16'h0, a}, {16'h0, b}, cin, sub, 16));
        if (first_acc < 0) first_acc = idx;
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_valid, overflow, cout, sum};
      step();
      idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_timeout", idx >= 2000, 0);
    chk("result_count", got, n);
    chk("latency", first_v - first_acc, STG);
    if (!bp) chk("throughput", last_d - first_d, n - 1);
  endtask

  task automatic sweep_chk(input string tag, input int i, input int l, input int w,
                           input logic v, input logic [33:0] act);
    logic expv;
    expv = (i >= l) && (i - l < 200);
    chk(tag, v, expv);
    if (expv) chk(tag, act, gold(ha[i-l], hb[i-l], hc[i-l], hs[i-l], w));
  endtask

  initial begin
    logic [31:0] fa [4];
    logic [31:0] fb [4];
    logic [1:0]  fcs [4];
    fa  = '{32'hFFFF_FFFF, 32'h7FFF_FF7F, 32'h8000_0080, 32'h0000_0003};
    fb  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
    fcs = '{2'b00, 2'b00, 2'b01, 2'b11};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_vld = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_rdy = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    one_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    one_op(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    one_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    one_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    one_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    stream(100, 1'b0);
    stream(80, 1'b1);

    // Reset mid-flight: four ops in, the first one stalled at the output.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 16'h1111 * 16'(k + 1); b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sum", sum, 16'h2222);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_valid", out_valid, 0);
      step();
    end
    one_op(16'hABCD, 16'h1111, 1'b0, 1'b1, 16'h9ABC, 1'b1, 1'b0);

    for (int i = 0; i < 212; i++) begin
      if (i < 200) begin
        sw_vld = 1'b1;
        if (i < 4) begin
          sw_a = fa[i]; sw_b = fb[i]; sw_cin = fcs[i][1]; sw_sub = fcs[i][0];
        end else begin
          sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
        end
        ha[i] = sw_a; hb[i] = sw_b; hc[i] = sw_cin; hs[i] = sw_sub;
      end else begin
        sw_vld = 1'b0;
      end
      #1;
      sweep_chk("sweep_8x1", i, 1, 8, v81, {o81, c81, 24'h0, s81});
      sweep_chk("sweep_8x8", i, 8, 8, v88, {o88, c88, 24'h0, s88});
      sweep_chk("sweep_32x4", i, 4, 32, v324, {o324, c324, s324});
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
